servo_slew_pwm: RTL and testbench
=================================

// Module: servo_slew_pwm
// PURPOSE
//   Downstream of the gait ROM sequencer: one instance per leg servo. Takes an 8-bit target
//   position, slews the applied position toward it by a bounded step per PWM frame, and emits
//   the hobby-servo PWM signal (1 ms..2 ms pulse, 20 ms frame). Prevents leg jerk when ROM steps jump.
// PARAMETERS
//   PERIOD_CYC  240000  clk cycles per PWM frame (20 ms @ 12 MHz)
//   MIN_PULSE   12000   pulse width in cycles for applied position 0 (1 ms)
//   STEP_CYC    47      extra pulse cycles per position unit (255*47+12000 = 23985 < PERIOD_CYC)
//   SLEW_MAX    4       max change of applied position per frame, 1..255
//   INIT_POS    128     applied/target position after reset (centre)
// PORTS
//   clk         in   1   system clock
//   rstn        in   1   synchronous reset, active low
//   enable      in   1   1 = generate pulses; 0 = output held low
//   pos         in   8   target position, 0..255
//   pos_valid   in   1   capture pos into target register this cycle
//   servo       out  1   PWM output to servo
//   cur_pos     out  8   position applied in current frame
//   busy        out  1   1 while cur_pos != target
//   frame_start out  1   one-cycle pulse on first cycle of each running frame
// BEHAVIOUR
// - Reset (rstn=0 at clk edge): state=IDLE, cnt=0, target=cur_pos=INIT_POS, width=MIN_PULSE+INIT_POS*STEP_CYC,
//   servo=0, busy=0, frame_start=0. Reset mid-pulse drops servo the following cycle.
// - target register: loaded from pos on any cycle with pos_valid=1, in any state.
// - FSM states:
//   IDLE: cnt held 0, servo=0. enable=1 -> RUN; next cycle is a frame boundary (cnt=0).
//   RUN:  cnt counts 0..PERIOD_CYC-1 and wraps to 0. enable sampled only on the last cycle of a frame
//         (cnt=PERIOD_CYC-1); if 0 -> IDLE. Dropping enable mid-frame never truncates a pulse.
// - Frame boundary (RUN, cnt=0): frame_start=1 for that cycle; cur_pos updated:
//   target>cur: cur += min(SLEW_MAX, target-cur); target<cur: cur -= min(SLEW_MAX, cur-target); else unchanged.
//   Differences computed in 9 bits; no wrap past 0 or 255. width = MIN_PULSE + new_cur*STEP_CYC,
//   computed combinationally from new cur and registered with it.
// - pos_valid on a boundary cycle: the boundary update uses the target value held BEFORE that write;
//   the new target takes effect at the next boundary. Latency target->first pulse change: <= 1 frame.
// - servo (registered): 1 in RUN for cnt in [1, width]; width cycles high, one cycle after frame_start.
//   Constant width within a frame; cur_pos changes only at boundaries.
// - busy = (cur_pos != target), registered, updated every cycle.
// - Counter width = clog2(PERIOD_CYC); no arithmetic overflow for parameter ranges above.
// TESTING (sim params PERIOD_CYC=100, MIN_PULSE=10, STEP_CYC=1, SLEW_MAX=4, INIT_POS=128)
// 1 Reset, enable=1: each frame servo high exactly 138 cycles? no -> use PERIOD_CYC=400: high 138 cycles,
//   frame_start every 400 cycles, busy=0, cur_pos=128.
// 2 pos=140 pos_valid 1 cycle: cur_pos 132,136,140 over 3 frames; widths 142,146,150; busy drops at 3rd boundary.
// 3 pos=0 from 2 (rate limit down): cur decrements 4/frame, reaches 0 after 35 frames, width 10, no underflow.
// 4 SLEW_MAX=255, pos=255 from 0: single-frame jump, width 265; then pos_valid on a boundary cycle:
//   applied only at following boundary.
// 5 enable 1->0 at cnt=50 inside a pulse: pulse completes full width, IDLE at frame end, servo stays 0;
//   re-enable: frame_start next cycle.
// 6 rstn=0 mid-pulse: servo=0 next cycle, cur_pos=target=128, busy=0; enable held 1 resumes with width 138.
```

Sim note for TESTING items 1–6: the bench uses PERIOD_CYC=400. PERIOD_CYC=100 is too short to contain a 265-cycle pulse. All other sim parameters are as listed.

Source files
------------

// File: rtl/servo_slew_pwm.sv
// Hobby-servo PWM generator with per-frame slew limiting of the applied position.
// The target can be written at any time; the applied position moves only on frame boundaries.
module servo_slew_pwm #(
  parameter int PERIOD_CYC = 240000,
  parameter int MIN_PULSE  = 12000,
  parameter int STEP_CYC   = 47,
  parameter int SLEW_MAX   = 4,
  parameter int INIT_POS   = 128
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic [7:0] pos,
  input  logic       pos_valid,
  output logic       servo,
  output logic [7:0] cur_pos,
  output logic       busy,
  output logic       frame_start
);
  localparam int              CW     = $clog2(PERIOD_CYC);
  localparam logic [0:0]      IDLE   = 1'b0;
  localparam logic [0:0]      RUN    = 1'b1;
  localparam logic [CW-1:0]   LAST   = CW'(PERIOD_CYC - 1);
  localparam logic [7:0]      SLEW8  = 8'(SLEW_MAX);
  localparam logic [7:0]      INIT8  = 8'(INIT_POS);
  localparam logic [CW-1:0]   INIT_W = CW'(MIN_PULSE + INIT_POS * STEP_CYC);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] width_q, width_d;
  logic [7:0]    tgt_q, tgt_d;
  logic [7:0]    cur_q, cur_d;
  logic          servo_q, servo_d;
  logic          busy_q, busy_d;
  logic          boundary;
  logic [8:0]    diff_up, diff_dn;
  logic [7:0]    step;

  assign boundary = (state_q == RUN) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    width_d = width_q;
    tgt_d   = pos_valid ? pos : tgt_q;
    diff_up = {1'b0, tgt_q} - {1'b0, cur_q};
    diff_dn = {1'b0, cur_q} - {1'b0, tgt_q};
    step    = '0;

    case (state_q)
      IDLE: if (enable) state_d = RUN;
      default: begin
        // enable only matters at the frame's last cycle so a pulse is never cut short
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!enable) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // slew uses the target held before any same-cycle write
    if (boundary) begin
      if (tgt_q > cur_q) begin
        step  = (diff_up < {1'b0, SLEW8}) ? diff_up[7:0] : SLEW8;
        cur_d = cur_q + step;
      end else if (tgt_q < cur_q) begin
        step  = (diff_dn < {1'b0, SLEW8}) ? diff_dn[7:0] : SLEW8;
        cur_d = cur_q - step;
      end
      width_d = CW'(MIN_PULSE) + CW'(cur_d) * CW'(STEP_CYC);
    end

    servo_d = (state_d == RUN) && (cnt_d != '0) && (cnt_d <= width_d);
    busy_d  = (cur_d != tgt_d);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= INIT8;
      cur_q   <= INIT8;
      width_q <= INIT_W;
      servo_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      width_q <= width_d;
      servo_q <= servo_d;
      busy_q  <= busy_d;
    end
  end

  assign servo       = servo_q;
  assign cur_pos     = cur_q;
  assign busy        = busy_q;
  assign frame_start = boundary;
endmodule

// File: tb/tb_servo_slew_pwm.sv
// Bench for servo_slew_pwm: per-frame table with a scoreboard of pulse widths, plus
// hand sequences for full-range jump, enable drop and mid-pulse reset.
module tb_servo_slew_pwm;
  localparam int PER  = 400;
  localparam int MINP = 10;
  localparam int STEP = 1;

  typedef struct {
    bit         wr;
    logic [7:0] pos;
    int         off;
    int         exp_cur;
  } vec_t;

  typedef struct {
    int c;
    int w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn, enable, pos_valid;
  logic [7:0] pos;
  logic       servo, busy, frame_start;
  logic [7:0] cur_pos;
  logic       rstn2, en2, pv2;
  logic [7:0] pos2;
  logic       servo2, busy2, fs2;
  logic [7:0] cur2;

  int         total = 0;
  int         bad = 0;
  exp_t       sbq[$];
  vec_t       tbl[50];
  logic [7:0] mcur, mtgt;
  int         gap_exp;
  bit         mon_en = 1'b0;
  int         mon_hi, mon_since;
  bit         mon_prev;

  always #5 clk = ~clk;

  servo_slew_pwm #(.PERIOD_CYC(PER), .MIN_PULSE(MINP), .STEP_CYC(STEP), .SLEW_MAX(4), .INIT_POS(128)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .pos(pos), .pos_valid(pos_valid),
    .servo(servo), .cur_pos(cur_pos), .busy(busy), .frame_start(frame_start));

  servo_slew_pwm #(.PERIOD_CYC(PER), .MIN_PULSE(MINP), .STEP_CYC(STEP), .SLEW_MAX(255), .INIT_POS(128)) dut2 (
    .clk(clk), .rstn(rstn2), .enable(en2), .pos(pos2), .pos_valid(pv2),
    .servo(servo2), .cur_pos(cur2), .busy(busy2), .frame_start(fs2));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [7:0] slew(input logic [7:0] c, input logic [7:0] t, input int sm);
    int d;
    d = int'(t) - int'(c);
    if (d > sm) d = sm;
    if (d < -sm) d = -sm;
    return 8'(int'(c) + d);
  endfunction

  // Monitor: measures each pulse of dut and compares against the queued frame expectation
  initial begin
    mon_hi = 0; mon_since = 1000; mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mon_hi = 0; mon_prev = 1'b0; mon_since = 1000;
      end else begin
        mon_since = frame_start ? 0 : mon_since + 1;
        if (servo && !mon_prev) chk("pulse_start_offset", mon_since, 1);
        if (servo) mon_hi++;
        if (!servo && mon_prev) begin
          if (sbq.size() == 0) fail_now("scoreboard_underrun");
          else begin
            exp_t e;
            e = sbq.pop_front();
            chk("pulse_width", mon_hi, e.w);
            chk("frame_cur_pos", int'(cur_pos), e.c);
          end
          mon_hi = 0;
        end
        mon_prev = servo;
      end
    end
  end

  // One dut frame: model the boundary update, push expectation, optionally write target
  task automatic frame(input bit wr, input logic [7:0] p, input int off);
    int   n;
    bit   got;
    exp_t e;
    n = 0; got = 1'b0;
    while (!got && n < 2 * PER) begin
      @(negedge clk); n++; got = frame_start;
    end
    if (!got) begin fail_now("frame_start_timeout"); return; end
    chk("frame_gap", n, gap_exp);
    mcur = slew(mcur, mtgt, 4);
    e.c = int'(mcur); e.w = MINP + int'(mcur) * STEP;
    sbq.push_back(e);
    repeat (off) @(negedge clk);
    if (wr) begin pos = p; pos_valid = 1'b1; mtgt = p; end
    @(negedge clk);
    pos_valid = 1'b0;
    chk("cur_after_boundary", int'(cur_pos), int'(mcur));
    chk("busy", int'(busy), int'(mcur != mtgt));
    gap_exp = PER - off - 1;
  endtask

  // One dut2 frame: returns applied position and high-cycle count
  task automatic meas2(input bit wr, input logic [7:0] p, output int c, output int hi);
    int n;
    n = 0; c = -1; hi = -1;
    while (!fs2 && n < 2 * PER) begin @(negedge clk); n++; end
    if (!fs2) begin fail_now("dut2_frame_timeout"); return; end
    if (wr) begin pos2 = p; pv2 = 1'b1; end
    @(negedge clk);
    pv2 = 1'b0;
    c = int'(cur2); hi = 0;
    for (int i = 1; i < PER; i++) begin
      if (servo2) hi++;
      if (i < PER - 1) @(negedge clk);
    end
  endtask

  initial begin
    int c, hi, quiet, n;
    tbl[0] = '{1'b0, 8'd0,   0,   128};
    tbl[1] = '{1'b1, 8'd140, 5,   128};
    tbl[2] = '{1'b0, 8'd0,   9,   132};
    tbl[3] = '{1'b0, 8'd0,   200, 136};
    tbl[4] = '{1'b0, 8'd0,   0,   140};
    tbl[5] = '{1'b1, 8'd0,   0,   140};
    for (int k = 1; k <= 35; k++) tbl[5+k] = '{1'b0, 8'd0, (k * 11) % 300, 140 - 4 * k};
    tbl[41] = '{1'b0, 8'd0,   0,   0};
    tbl[42] = '{1'b1, 8'd2,   0,   0};
    tbl[43] = '{1'b0, 8'd0,   0,   2};
    tbl[44] = '{1'b1, 8'd255, 100, 2};
    tbl[45] = '{1'b0, 8'd0,   0,   6};
    tbl[46] = '{1'b1, 8'd3,   0,   10};
    tbl[47] = '{1'b0, 8'd0,   0,   6};
    tbl[48] = '{1'b0, 8'd0,   0,   3};
    tbl[49] = '{1'b0, 8'd0,   0,   3};

    rstn = 1'b0; enable = 1'b0; pos = '0; pos_valid = 1'b0;
    rstn2 = 1'b0; en2 = 1'b0; pos2 = '0; pv2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cur_pos", int'(cur_pos), 128);
    chk("rst_busy", int'(busy), 0);
    chk("rst_servo", int'(servo), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst2_cur_pos", int'(cur2), 128);

    rstn = 1'b1;
    @(negedge clk);
    chk("idle_frame_start", int'(frame_start), 0);
    enable = 1'b1; mon_en = 1'b1; gap_exp = 1; mcur = 8'd128; mtgt = 8'd128;
    for (int i = 0; i < 50; i++) begin
      frame(tbl[i].wr, tbl[i].pos, tbl[i].off);
      chk("table_cur_pos", int'(cur_pos), tbl[i].exp_cur);
    end
    repeat (300) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    mon_en = 1'b0;

    // full-range jump with SLEW_MAX=255, then a write landing on a boundary cycle
    rstn2 = 1'b1; en2 = 1'b1; pos2 = 8'd0; pv2 = 1'b1;
    @(negedge clk);
    pv2 = 1'b0;
    meas2(1'b0, 8'd0, c, hi);
    chk("jump_cur0", c, 0);
    chk("jump_width0", hi, 10);
    pos2 = 8'd255; pv2 = 1'b1;
    @(negedge clk);
    pv2 = 1'b0;
    meas2(1'b0, 8'd0, c, hi);
    chk("jump_cur255", c, 255);
    chk("jump_width265", hi, 265);
    chk("jump_busy_clear", int'(busy2), 0);
    meas2(1'b1, 8'd100, c, hi);
    chk("bwrite_old_target_cur", c, 255);
    chk("bwrite_old_target_width", hi, 265);
    chk("bwrite_busy", int'(busy2), 1);
    meas2(1'b0, 8'd0, c, hi);
    chk("bwrite_applied_cur", c, 100);
    chk("bwrite_applied_width", hi, 110);

    // enable dropped inside a pulse
    pos2 = 8'd255; pv2 = 1'b1;
    @(negedge clk);
    pv2 = 1'b0;
    repeat (50) @(negedge clk);
    chk("drop_servo_at_cnt50", int'(servo2), 1);
    en2 = 1'b0;
    hi = 0;
    for (int i = 50; i < PER; i++) begin
      if (servo2) hi++;
      if (i < PER - 1) @(negedge clk);
    end
    chk("drop_pulse_tail", hi, 216);
    quiet = 0;
    repeat (450) begin
      @(negedge clk);
      if (servo2 || fs2) quiet++;
    end
    chk("idle_quiet", quiet, 0);
    en2 = 1'b1;
    @(negedge clk);
    chk("reenable_frame_start", int'(fs2), 1);
    meas2(1'b0, 8'd0, c, hi);
    chk("reenable_width", hi, 265);

    // reset in the middle of a pulse
    n = 0;
    while (!frame_start && n < 2 * PER) begin @(negedge clk); n++; end
    if (!frame_start) fail_now("pre_reset_frame_timeout");
    repeat (5) @(negedge clk);
    chk("pre_reset_servo", int'(servo), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset_servo", int'(servo), 0);
    chk("midreset_cur_pos", int'(cur_pos), 128);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_frame_start", int'(frame_start), 0);
    rstn = 1'b1; sbq.delete(); mcur = 8'd128; mtgt = 8'd128; gap_exp = 1; mon_en = 1'b1;
    frame(1'b0, 8'd0, 0);
    frame(1'b0, 8'd0, 0);
    repeat (200) @(negedge clk);
    chk("scoreboard_drained_after_reset", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
